// File: rtl/tlight_pkg.sv
// Shared types and constants for the intersection lamp conflict monitor.
package tlight_pkg;

  typedef enum logic [1:0] {STARTUP, MONITOR, FAULT} state_e;
  typedef enum logic [1:0] {GO, YEL, STOP} phase_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_CONFLICT = 2'd1;
  localparam logic [1:0] FC_DARK     = 2'd2;
  localparam logic [1:0] FC_SHORTY   = 2'd3;

  localparam logic [1:0] HD_W = 2'd0;
  localparam logic [1:0] HD_E = 2'd1;
  localparam logic [1:0] HD_S = 2'd2;
  localparam logic [1:0] HD_N = 2'd3;

  // Vehicle head bit positions {R,Y,L,G}; pedestrian heads are {R,G}.
  localparam int LB_R = 3;
  localparam int LB_Y = 2;
  localparam int LB_L = 1;
  localparam int LB_G = 0;
  localparam int PB_G = 0;

  // Lowest-numbered head wins (W > E > S > N).
  function automatic logic [1:0] first_head(input logic [3:0] v);
    if (v[0])      return HD_W;
    else if (v[1]) return HD_E;
    else if (v[2]) return HD_S;
    else           return HD_N;
  endfunction

endpackage

// File: rtl/tlight_head_check.sv
// Per-vehicle-head checker: dark/multi persistence counter and yellow-duration tracker.
module tlight_head_check
  import tlight_pkg::*;
#(
  parameter int PERSIST    = 2,
  parameter int MIN_YELLOW = 3
) (
  input  logic       Cp,
  input  logic       reset,
  input  logic       hold,
  input  logic       restart,
  input  logic [3:0] lamp,
  output logic       dm_cond,
  output logic       dm_evt,
  output logic       sy_evt
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);

  logic [CW-1:0] dm_cnt_q, dm_cnt_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  phase_e        phase_q, phase_d;
  logic          go_on;

  assign go_on   = lamp[LB_G] | lamp[LB_L];
  assign dm_cond = (lamp == 4'b0000) | (lamp[LB_R] & (lamp[LB_Y] | go_on));

  always_comb begin
    dm_cnt_d = '0;
    dm_evt   = 1'b0;
    phase_d  = phase_q;
    ycnt_d   = ycnt_q;
    sy_evt   = 1'b0;
    if (!hold) begin
      if (dm_cond)
        dm_cnt_d = (dm_cnt_q == CW'(PERSIST)) ? dm_cnt_q : dm_cnt_q + 1'b1;
      dm_evt = dm_cond && (dm_cnt_d == CW'(PERSIST));

      if (go_on) begin
        phase_d = GO;
      end else begin
        unique case (phase_q)
          GO: begin
            if (lamp[LB_Y]) begin
              phase_d = YEL;
              ycnt_d  = YW'(1);
            end else if (lamp[LB_R]) begin
              // Green straight to red skips yellow entirely.
              phase_d = STOP;
              sy_evt  = 1'b1;
            end
          end
          YEL: begin
            if (lamp[LB_R]) begin
              phase_d = STOP;
              sy_evt  = (ycnt_q < YW'(MIN_YELLOW));
            end else if (lamp[LB_Y]) begin
              ycnt_d = (ycnt_q == YW'(MIN_YELLOW)) ? ycnt_q : ycnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    if (hold || restart) begin
      phase_d = STOP;
      ycnt_d  = '0;
    end
  end

  always_ff @(posedge Cp) begin
    if (reset) begin
      dm_cnt_q <= '0;
      ycnt_q   <= '0;
      phase_q  <= STOP;
    end else begin
      dm_cnt_q <= dm_cnt_d;
      ycnt_q   <= ycnt_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: rtl/tlight_monitor.sv
// Lamp conflict monitor: latches the first unsafe lamp combination and requests all-red flash.
module tlight_monitor
  import tlight_pkg::*;
#(
  parameter int PERSIST    = 2,
  parameter int MIN_YELLOW = 3,
  parameter int START_HOLD = 4,
  parameter int FLASH_DIV  = 5
) (
  input  logic       Cp,
  input  logic       reset,
  input  logic [3:0] lamp_w,
  input  logic [3:0] lamp_e,
  input  logic [3:0] lamp_s,
  input  logic [3:0] lamp_n,
  input  logic [1:0] ped_ww,
  input  logic [1:0] ped_ew,
  input  logic [1:0] ped_sw,
  input  logic [1:0] ped_nw,
  input  logic       clr,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] fault_head,
  output logic       flash,
  output logic       flash_lamp
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam int HW = $clog2(START_HOLD + 1);
  localparam int DW = $clog2(FLASH_DIV + 1);

  logic [3:0]    lamp_arr [4];
  logic [3:0]    dm_cond, dm_evt, sy_evt;
  logic          hold, restart, ew_go, ns_go, conflict, any_cond, conf_evt;
  logic          unused_ped_r;
  logic [CW-1:0] conf_cnt_q, conf_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] div_q, div_d;
  state_e        state_q, state_d;
  logic          fault_q, fault_d, flash_lamp_q, flash_lamp_d;
  logic [1:0]    code_q, code_d, head_q, head_d;

  assign lamp_arr[HD_W] = lamp_w;
  assign lamp_arr[HD_E] = lamp_e;
  assign lamp_arr[HD_S] = lamp_s;
  assign lamp_arr[HD_N] = lamp_n;

  assign unused_ped_r = ^{ped_ww[1], ped_ew[1], ped_sw[1], ped_nw[1]};

  assign ew_go = lamp_w[LB_G] | lamp_w[LB_L] | lamp_e[LB_G] | lamp_e[LB_L]
               | ped_ww[PB_G] | ped_ew[PB_G];
  assign ns_go = lamp_s[LB_G] | lamp_s[LB_L] | lamp_n[LB_G] | lamp_n[LB_L]
               | ped_sw[PB_G] | ped_nw[PB_G];
  assign conflict = ew_go & ns_go;
  assign any_cond = conflict | (|dm_cond);
  assign hold     = (state_q == STARTUP);
  assign restart  = (state_q == FAULT) && clr && !any_cond;

  for (genvar gi = 0; gi < 4; gi++) begin : g_head
    tlight_head_check #(
      .PERSIST   (PERSIST),
      .MIN_YELLOW(MIN_YELLOW)
    ) u_head (
      .Cp     (Cp),
      .reset  (reset),
      .hold   (hold),
      .restart(restart),
      .lamp   (lamp_arr[gi]),
      .dm_cond(dm_cond[gi]),
      .dm_evt (dm_evt[gi]),
      .sy_evt (sy_evt[gi])
    );
  end

  always_comb begin
    conf_cnt_d = '0;
    if (!hold && conflict)
      conf_cnt_d = (conf_cnt_q == CW'(PERSIST)) ? conf_cnt_q : conf_cnt_q + 1'b1;
    conf_evt = conflict && (conf_cnt_d == CW'(PERSIST));
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    fault_d      = fault_q;
    code_d       = code_q;
    head_d       = head_q;
    flash_lamp_d = flash_lamp_q;
    div_d        = div_q;
    unique case (state_q)
      STARTUP: begin
        if (hold_cnt_q == HW'(START_HOLD - 1)) state_d = MONITOR;
        else                                   hold_cnt_d = hold_cnt_q + 1'b1;
      end
      MONITOR: begin
        if (conf_evt || (|dm_evt) || (|sy_evt)) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          flash_lamp_d = 1'b1;
          div_d        = '0;
          if (conf_evt) begin
            code_d = FC_CONFLICT;
            head_d = HD_W;
          end else if (|dm_evt) begin
            code_d = FC_DARK;
            head_d = first_head(dm_evt);
          end else begin
            code_d = FC_SHORTY;
            head_d = first_head(sy_evt);
          end
        end
      end
      FAULT: begin
        if (restart) begin
          state_d      = MONITOR;
          fault_d      = 1'b0;
          code_d       = FC_NONE;
          head_d       = HD_W;
          flash_lamp_d = 1'b0;
          div_d        = '0;
        end else if (div_q == DW'(FLASH_DIV - 1)) begin
          flash_lamp_d = ~flash_lamp_q;
          div_d        = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge Cp) begin
    if (reset) begin
      state_q      <= STARTUP;
      hold_cnt_q   <= '0;
      conf_cnt_q   <= '0;
      div_q        <= '0;
      fault_q      <= 1'b0;
      code_q       <= FC_NONE;
      head_q       <= HD_W;
      flash_lamp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      conf_cnt_q   <= conf_cnt_d;
      div_q        <= div_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      head_q       <= head_d;
      flash_lamp_q <= flash_lamp_d;
    end
  end

  assign fault      = fault_q;
  assign flash      = fault_q;
  assign fault_code = code_q;
  assign fault_head = head_q;
  assign flash_lamp = flash_lamp_q;

endmodule

// File: tb/tb_tlight_monitor.sv
// Directed bench for tlight_monitor; expectations queued per step and checked after each edge.
module tb_tlight_monitor;

  localparam logic [3:0] LR = 4'b1000;
  localparam logic [3:0] LY = 4'b0100;
  localparam logic [3:0] LG = 4'b0001;
  localparam logic [3:0] LD = 4'b0000;
  localparam logic [3:0] LM = 4'b1001;
  localparam logic [1:0] PR = 2'b10;
  localparam logic [1:0] PG = 2'b01;

  typedef struct packed {
    logic       f;
    logic [1:0] c;
    logic [1:0] h;
    logic       fl;
  } exp_t;

  logic       Cp = 1'b0;
  logic       reset, clr;
  logic [3:0] lamp_w, lamp_e, lamp_s, lamp_n;
  logic [1:0] ped_ww, ped_ew, ped_sw, ped_nw;
  logic       fault, flash, flash_lamp;
  logic [1:0] fault_code, fault_head;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  tlight_monitor dut (
    .Cp        (Cp),
    .reset     (reset),
    .lamp_w    (lamp_w),
    .lamp_e    (lamp_e),
    .lamp_s    (lamp_s),
    .lamp_n    (lamp_n),
    .ped_ww    (ped_ww),
    .ped_ew    (ped_ew),
    .ped_sw    (ped_sw),
    .ped_nw    (ped_nw),
    .clr       (clr),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_head(fault_head),
    .flash     (flash),
    .flash_lamp(flash_lamp)
  );

  always #5 Cp = ~Cp;

  task automatic check_out(input string tag);
    exp_t       ex;
    logic [6:0] obs, req;
    ex  = sb_q.pop_front();
    obs = {fault, fault_code, fault_head, flash, flash_lamp};
    req = {ex.f, ex.c, ex.h, ex.f, ex.fl};
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed {f,code,head,flash,fl}=%b expected=%b", tag, obs, req);
    end
    $display("step %-10s t=%0t obs=%b exp=%b", tag, $time, obs, req);
  endtask

  task automatic drive(input string tag, input logic rst, input logic cl,
                       input logic [3:0] w, input logic [3:0] e,
                       input logic [3:0] s, input logic [3:0] n,
                       input logic [1:0] psw,
                       input logic f, input logic [1:0] c,
                       input logic [1:0] h, input logic fl);
    exp_t ex;
    reset  = rst;
    clr    = cl;
    lamp_w = w;
    lamp_e = e;
    lamp_s = s;
    lamp_n = n;
    ped_sw = psw;
    ex = '{f: f, c: c, h: h, fl: fl};
    sb_q.push_back(ex);
    @(posedge Cp);
    #1;
    check_out(tag);
  endtask

  initial begin
    ped_ww = PR;
    ped_ew = PR;
    ped_nw = PR;

    drive("reset0", 1, 0, LR, LR, LR, LR, PR, 0, 0, 0, 0);
    drive("reset1", 1, 0, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive("hold", 0, 0, LG, LG, LR, LR, PR, 0, 0, 0, 0);

    // Nominal cycle: EW green, 3 yellow, all red, NS green, 3 yellow, all red.
    for (int i = 0; i < 3; i++) drive("ew_grn", 0, 0, LG, LG, LR, LR, PR, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("ew_yel", 0, 0, LY, LY, LR, LR, PR, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive("allred", 0, 0, LR, LR, LR, LR, PR, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("ns_grn", 0, 0, LR, LR, LG, LG, PR, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("ns_yel", 0, 0, LR, LR, LY, LY, PR, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive("allred", 0, 0, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // One-cycle conflict (pedestrian) is filtered; two-cycle conflict faults.
    drive("ped_blip", 0, 0, LG, LR, LR, LR, PG, 0, 0, 0, 0);
    drive("ped_drop", 0, 0, LG, LR, LR, LR, PR, 0, 0, 0, 0);
    drive("conf1",    0, 0, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    drive("conf2",    0, 0, LG, LR, LG, LR, PR, 1, 1, 0, 1);
    for (int i = 1; i <= 12; i++)
      drive("flash", 0, 0, LG, LR, LG, LR, PR, 1, 1, 0, ((i / 5) % 2) == 0);
    drive("clr_held", 0, 1, LG, LR, LG, LR, PR, 1, 1, 0, 1);
    drive("frozen",   0, 0, LG, LD, LG, LR, PR, 1, 1, 0, 1);
    drive("frozen",   0, 0, LG, LD, LG, LR, PR, 1, 1, 0, 0);
    drive("unclr",    0, 0, LR, LR, LR, LR, PR, 1, 1, 0, 0);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);
    drive("idle",     0, 0, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // Dark E head; clear refused while still dark.
    drive("e_dark1",  0, 0, LR, LD, LR, LR, PR, 0, 0, 0, 0);
    drive("e_dark2",  0, 0, LR, LD, LR, LR, PR, 1, 2, 1, 1);
    drive("dark_clr", 0, 1, LR, LD, LR, LR, PR, 1, 2, 1, 1);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // Conflict beats simultaneous multi on N.
    drive("prio1",    0, 0, LG, LR, LG, LM, PR, 0, 0, 0, 0);
    drive("prio2",    0, 0, LG, LR, LG, LM, PR, 1, 1, 0, 1);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // Two dark heads: lowest index reported.
    drive("dark2h1",  0, 0, LR, LD, LD, LR, PR, 0, 0, 0, 0);
    drive("dark2h2",  0, 0, LR, LD, LD, LR, PR, 1, 2, 1, 1);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // Short yellow on N, then direct green-to-red on S.
    drive("n_grn",    0, 0, LR, LR, LR, LG, PR, 0, 0, 0, 0);
    drive("n_yel",    0, 0, LR, LR, LR, LY, PR, 0, 0, 0, 0);
    drive("n_yel",    0, 0, LR, LR, LR, LY, PR, 0, 0, 0, 0);
    drive("n_red",    0, 0, LR, LR, LR, LR, PR, 1, 3, 3, 1);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);
    drive("s_grn",    0, 0, LR, LR, LG, LR, PR, 0, 0, 0, 0);
    drive("s_red",    0, 0, LR, LR, LR, LR, PR, 1, 3, 2, 1);
    drive("clr_ok",   0, 1, LR, LR, LR, LR, PR, 0, 0, 0, 0);

    // Reset mid-fault, conflict ignored during hold, faults afterward.
    drive("conf1",    0, 0, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    drive("conf2",    0, 0, LG, LR, LG, LR, PR, 1, 1, 0, 1);
    drive("rst_mid",  1, 1, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive("hold_conf", 0, 0, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    drive("post1",    0, 0, LG, LR, LG, LR, PR, 0, 0, 0, 0);
    drive("post2",    0, 0, LG, LR, LG, LR, PR, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
